reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
// - Writer end of the register-file write port (regwrite/wa/wd). Merges ALU results and load returns into one registered write per cycle.
// - ALU source uses a valid/ready handshake. The load source has no back-pressure, so loads are buffered in a small queue.
// - Flags reads of registers with a write still pending, for hazard/stall logic in decode.
// PARAMETERS
// - WIDTH    32  data width, matches register-file width
// - REGBITS  5   register-address width (2**REGBITS registers)
// - LQ_DEPTH 2   load-queue entries, power of two, >=2
// PORTS
// - clk        in   1                 clock, all state updates on posedge
// - reset      in   1                 synchronous, active-high
// - wb_hold    in   1                 write port borrowed this cycle: no write issued
// - alu_valid  in   1                 ALU result offered
// - alu_ready  out  1                 ALU result accepted this cycle (comb)
// - alu_wa     in   REGBITS           ALU destination register
// - alu_wd     in   WIDTH             ALU result
// - ld_valid   in   1                 load return, must be taken or dropped
// - ld_wa      in   REGBITS           load destination register
// - ld_wd      in   WIDTH             load data
// - ld_full    out  1                 queue full; issuer must not launch new loads
// - lq_count   out  $clog2(LQ_DEPTH)+1  queue occupancy (registered)
// - overflow   out  1                 sticky: a load return was dropped
// - ra1, ra2   in   REGBITS           decode read addresses
// - pend1, pend2 out 1                ra1/ra2 has a queued or in-flight write (comb)
// - regwrite   out  1                 register-file write enable (registered)
// - wa         out  REGBITS           register-file write address (registered)
// - wd         out  WIDTH             register-file write data (registered)
// BEHAVIOUR
// - Reset: regwrite=0, wa=0, wd=0, lq_count=0, overflow=0. Queue pointers are cleared; entry contents are don't-care.
// - Reset applied mid-operation discards all queued loads and the pending output write.
// - Each cycle, one source is selected for the output register. Priority: wb_hold > queue head > ALU.
//   - wb_hold=1: next regwrite=0, no pop, alu_ready=0.
//   - else lq_count!=0: pop head; next {regwrite,wa,wd} = head; alu_ready=0.
//   - else alu_ready=1; if alu_valid, next write = ALU; otherwise next regwrite=0.
// - Latency:
//   - ALU accept -> regwrite high on the next cycle (1 cycle).
//   - Load with an empty queue -> enqueued at edge N, written at edge N+1, so regwrite is high 2 cycles after ld_valid.
// - Register 0: an entry with wa==0 is consumed normally but drives regwrite=0 (write suppressed).
// - Queue:
//   - Push when ld_valid; pop as selected above. Push and pop in the same cycle are allowed; count is unchanged.
//   - Push with count==LQ_DEPTH and no pop: data dropped, count unchanged, overflow set (sticky until reset).
//   - ld_full = (lq_count==LQ_DEPTH). Pointers wrap modulo LQ_DEPTH.
//   - Order: loads are written in arrival order. No ALU result is written while any load is queued.
// - Pending flags: pendN=1 if raN!=0 and raN matches either:
//   - the wa of any valid queue entry, including one being pushed this cycle; or
//   - wa while regwrite=1 (the register file updates at the next edge).
//   - ALU inputs are not checked; forwarding covers them.
// - Arithmetic: none. Only counter and pointers; lq_count never exceeds LQ_DEPTH.
// STRUCTURE
// - Shared header mips_defs.vh holds the WIDTH/REGBITS defaults used by the register file and this block.
// - Sub-module wb_fifo (WIDTH+REGBITS wide, LQ_DEPTH deep):
//   - ports: push, pop, din, dout, count, full, empty, drop
//   - plus a per-entry valid/addr view for the pending compare.
// - Top level: priority mux, output register, pending comparators, overflow flop.
// TESTING
// - ALU only: alu_valid=1, wa=5, wd=0x1234 -> alu_ready=1; next cycle regwrite=1, wa=5, wd=0x1234.
// - Load vs ALU: ld_valid (wa=7, wd=0xAA) and alu_valid (wa=3) in cycle 0.
//   -> ALU written cycle 1; alu_ready=0 in cycle 1; load written cycle 2; ALU written cycle 3 if held valid.
// - Hold fill: wb_hold=1, three loads with LQ_DEPTH=2 -> ld_full=1 after 2; third dropped, overflow=1.
//   After release: two writes in order; overflow stays 1 until reset.
// - Register 0: ALU result with wa=0 -> alu_ready=1; regwrite stays 0 the next cycle.
// - Pending: queued load wa=9, ra1=9 -> pend1=1 until the write cycle ends; ra2=0 -> pend2=0 always.
// - Mid-operation reset: reset with 2 queued loads -> next cycle lq_count=0, regwrite=0, overflow=0; no stale writes follow.

Source files
------------

// File: rtl/reg_writeback_pkg.sv
// Shared defaults and types for the register-file writeback block.
// WIDTH/REGBITS defaults match the register file this block feeds.
package reg_writeback_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_REGBITS  = 5;
  localparam int DEF_LQ_DEPTH = 2;

  // Source feeding the output write register in a given cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_ALU  = 2'd2
  } src_e;

  // Occupancy counters need one extra bit so they can hold the full depth
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bus bundle between the execute/memory stages, decode hazard logic and
// the register-file write port.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REGBITS  = DEF_REGBITS,
  parameter int LQ_DEPTH = DEF_LQ_DEPTH
) ();

  logic                         wb_hold;
  logic                         alu_valid;
  logic                         alu_ready;
  logic [REGBITS-1:0]           alu_wa;
  logic [WIDTH-1:0]             alu_wd;
  logic                         ld_valid;
  logic [REGBITS-1:0]           ld_wa;
  logic [WIDTH-1:0]             ld_wd;
  logic                         ld_full;
  logic [cnt_w(LQ_DEPTH)-1:0]   lq_count;
  logic                         overflow;
  logic [REGBITS-1:0]           ra1;
  logic [REGBITS-1:0]           ra2;
  logic                         pend1;
  logic                         pend2;
  logic                         regwrite;
  logic [REGBITS-1:0]           wa;
  logic [WIDTH-1:0]             wd;

  modport master (
    output wb_hold, alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, ra1, ra2,
    input  alu_ready, ld_full, lq_count, overflow, pend1, pend2, regwrite, wa, wd
  );

  modport slave (
    input  wb_hold, alu_valid, alu_wa, alu_wd, ld_valid, ld_wa, ld_wd, ra1, ra2,
    output alu_ready, ld_full, lq_count, overflow, pend1, pend2, regwrite, wa, wd
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Small load-return queue with drop-on-full and a per-entry address view
// so the hazard logic can see every queued destination register.
module wb_fifo #(
  parameter int DW    = 37,
  parameter int DEPTH = 2,
  parameter int AW    = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DW-1:0]              din,
  output logic [DW-1:0]              dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       drop,
  output logic [DEPTH-1:0]           ent_valid,
  output logic [DEPTH-1:0][AW-1:0]   ent_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Entry i is live when its distance from the head is below the occupancy
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] off;
      off          = PW'(i) - rd_ptr;
      ent_valid[i] = ({1'b0, off} < count);
      ent_addr[i]  = mem[i][DW-1 -: AW];
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file writeback: merges ALU results and queued load returns into
// one registered write per cycle and flags reads of pending destinations.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int REGBITS  = DEF_REGBITS,
  parameter int LQ_DEPTH = DEF_LQ_DEPTH
) (
  input  logic           clk,
  input  logic           reset,
  reg_writeback_if.slave bus
);

  localparam int CW = cnt_w(LQ_DEPTH);
  localparam int EW = WIDTH + REGBITS;

  src_e                            sel;
  logic                            pop;
  logic                            push_acc;
  logic                            fifo_full;
  logic                            fifo_empty;
  logic                            fifo_drop;
  logic [EW-1:0]                   head;
  logic [REGBITS-1:0]              head_wa;
  logic [WIDTH-1:0]                head_wd;
  logic [CW-1:0]                   count;
  logic [LQ_DEPTH-1:0]             ent_valid;
  logic [LQ_DEPTH-1:0][REGBITS-1:0] ent_addr;
  logic                            regwrite_p0;
  logic [REGBITS-1:0]              wa_p0;
  logic [WIDTH-1:0]                wd_p0;
  logic                            overflow_q;

  wb_fifo #(
    .DW    (EW),
    .DEPTH (LQ_DEPTH),
    .AW    (REGBITS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.ld_valid),
    .pop       (pop),
    .din       ({bus.ld_wa, bus.ld_wd}),
    .dout      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop),
    .ent_valid (ent_valid),
    .ent_addr  (ent_addr)
  );

  assign {head_wa, head_wd} = head;

  // Borrowed port beats everything; queued loads always drain before ALU results
  always_comb begin
    sel = SRC_NONE;
    if (!bus.wb_hold) sel = fifo_empty ? SRC_ALU : SRC_LOAD;
  end

  assign pop           = (sel == SRC_LOAD);
  assign bus.alu_ready = (sel == SRC_ALU);
  assign push_acc      = bus.ld_valid && (!fifo_full || pop);

  function automatic logic is_pending(input logic [REGBITS-1:0] ra);
    logic hit;
    hit = regwrite_p0 && (wa_p0 == ra);
    if (push_acc && (bus.ld_wa == ra)) hit = 1'b1;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i] == ra)) hit = 1'b1;
    end
    return hit && (ra != '0);
  endfunction

  always_comb begin
    bus.pend1 = is_pending(bus.ra1);
    bus.pend2 = is_pending(bus.ra2);
  end

  // ---- output write register (p0) ----
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_p0 <= 1'b0;
      wa_p0       <= '0;
      wd_p0       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (sel)
        SRC_LOAD: begin
          regwrite_p0 <= (head_wa != '0);
          wa_p0       <= head_wa;
          wd_p0       <= head_wd;
        end
        SRC_ALU: begin
          regwrite_p0 <= bus.alu_valid && (bus.alu_wa != '0);
          if (bus.alu_valid) begin
            wa_p0 <= bus.alu_wa;
            wd_p0 <= bus.alu_wd;
          end
        end
        default: regwrite_p0 <= 1'b0;
      endcase
      if (fifo_drop) overflow_q <= 1'b1;
    end
  end

  assign bus.regwrite = regwrite_p0;
  assign bus.wa       = wa_p0;
  assign bus.wd       = wd_p0;
  assign bus.ld_full  = fifo_full;
  assign bus.lq_count = count;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, reset sequences and a
// randomized run checked against a queue-based reference model.
module tb_reg_writeback;
  import reg_writeback_pkg::*;

  localparam int WIDTH    = 32;
  localparam int REGBITS  = 5;
  localparam int LQ_DEPTH = 2;
  localparam int NVEC     = 29;

  typedef logic [REGBITS-1:0] ra_t;
  typedef logic [WIDTH-1:0]   d_t;

  typedef struct {
    logic hold; logic av; ra_t awa; d_t awd;
    logic lv; ra_t lwa; d_t lwd; ra_t ra1; ra_t ra2;
  } in_t;

  typedef struct {
    logic rdy; logic rw; ra_t wa; d_t wd; int cnt;
    logic full; logic ovf; logic p1; logic p2;
  } out_t;

  typedef struct { in_t i; out_t o; } vec_t;
  typedef struct { ra_t wa; d_t wd; } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_writeback_if #(.WIDTH(WIDTH), .REGBITS(REGBITS), .LQ_DEPTH(LQ_DEPTH)) bus ();

  reg_writeback #(.WIDTH(WIDTH), .REGBITS(REGBITS), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   tests  = 0;
  int   failed = 0;
  vec_t tbl [NVEC];
  in_t  idle;

  // Reference model: the load queue is a plain SV queue, output write is a record
  ent_t mq[$];
  logic m_rw;
  ra_t  m_wa;
  d_t   m_wd;
  logic m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v, input logic rst);
    @(negedge clk);
    reset         = rst;
    bus.wb_hold   = v.hold;
    bus.alu_valid = v.av;
    bus.alu_wa    = v.awa;
    bus.alu_wd    = v.awd;
    bus.ld_valid  = v.lv;
    bus.ld_wa     = v.lwa;
    bus.ld_wd     = v.lwd;
    bus.ra1       = v.ra1;
    bus.ra2       = v.ra2;
    #1;
  endtask

  task automatic check_out(input out_t e, input string tag);
    chk({tag, ".alu_ready"}, 32'(bus.alu_ready), 32'(e.rdy));
    chk({tag, ".regwrite"},  32'(bus.regwrite),  32'(e.rw));
    if (e.rw) begin
      chk({tag, ".wa"}, 32'(bus.wa), 32'(e.wa));
      chk({tag, ".wd"}, bus.wd, e.wd);
    end
    chk({tag, ".lq_count"}, 32'(bus.lq_count), e.cnt);
    chk({tag, ".ld_full"},  32'(bus.ld_full),  32'(e.full));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(e.ovf));
    chk({tag, ".pend1"},    32'(bus.pend1),    32'(e.p1));
    chk({tag, ".pend2"},    32'(bus.pend2),    32'(e.p2));
  endtask

  function automatic logic model_pend(input ra_t ra, input in_t v, input logic push_ok);
    if (ra == 0) return 1'b0;
    if (m_rw && m_wa == ra) return 1'b1;
    if (push_ok && v.lwa == ra) return 1'b1;
    foreach (mq[k]) if (mq[k].wa == ra) return 1'b1;
    return 1'b0;
  endfunction

  function automatic out_t model_expect(input in_t v);
    out_t e;
    logic pop, push_ok;
    pop     = !v.hold && (mq.size() != 0);
    push_ok = v.lv && ((mq.size() < LQ_DEPTH) || pop);
    e.rdy   = !v.hold && (mq.size() == 0);
    e.rw    = m_rw;
    e.wa    = m_wa;
    e.wd    = m_wd;
    e.cnt   = mq.size();
    e.full  = (mq.size() == LQ_DEPTH);
    e.ovf   = m_ovf;
    e.p1    = model_pend(v.ra1, v, push_ok);
    e.p2    = model_pend(v.ra2, v, push_ok);
    return e;
  endfunction

  task automatic model_step(input in_t v, input logic rst);
    ent_t h;
    if (rst) begin
      mq.delete();
      m_rw = 0; m_wa = 0; m_wd = 0; m_ovf = 0;
      return;
    end
    if (v.hold) begin
      m_rw = 0;
    end else if (mq.size() != 0) begin
      h = mq.pop_front();
      m_rw = (h.wa != 0); m_wa = h.wa; m_wd = h.wd;
    end else if (v.av) begin
      m_rw = (v.awa != 0); m_wa = v.awa; m_wd = v.awd;
    end else begin
      m_rw = 0;
    end
    if (v.lv) begin
      if (mq.size() < LQ_DEPTH) mq.push_back('{wa: v.lwa, wd: v.lwd});
      else m_ovf = 1;
    end
  endtask

  function automatic vec_t row(
    input logic hold, input logic av, input ra_t awa, input d_t awd,
    input logic lv, input ra_t lwa, input d_t lwd, input ra_t ra1, input ra_t ra2,
    input logic rdy, input logic rw, input ra_t wa, input d_t wd, input int cnt,
    input logic full, input logic ovf, input logic p1, input logic p2);
    vec_t r;
    r.i = '{hold: hold, av: av, awa: awa, awd: awd, lv: lv, lwa: lwa, lwd: lwd, ra1: ra1, ra2: ra2};
    r.o = '{rdy: rdy, rw: rw, wa: wa, wd: wd, cnt: cnt, full: full, ovf: ovf, p1: p1, p2: p2};
    return r;
  endfunction

  initial begin
    idle = '{hold: 0, av: 0, awa: 0, awd: 0, lv: 0, lwa: 0, lwd: 0, ra1: 0, ra2: 0};

    //              hold av awa awd       lv lwa lwd    ra1 ra2  rdy rw wa wd        cnt full ovf p1 p2
    tbl[0]  = row(0, 0, 0, 0,        0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 0, 0, 0);
    tbl[1]  = row(0, 1, 5, 32'h1234, 0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 0, 0, 0);
    tbl[2]  = row(0, 0, 0, 0,        0, 0,  0,     5,  0,   1, 1, 5,  32'h1234, 0, 0, 0, 1, 0);
    tbl[3]  = row(0, 0, 0, 0,        0, 0,  0,     5,  0,   1, 0, 0,  0,        0, 0, 0, 0, 0);
    tbl[4]  = row(0, 1, 3, 32'h33,   1, 7,  32'hAA, 7, 0,   1, 0, 0,  0,        0, 0, 0, 1, 0);
    tbl[5]  = row(0, 1, 3, 32'h33,   0, 0,  0,     7,  3,   0, 1, 3,  32'h33,   1, 0, 0, 1, 1);
    tbl[6]  = row(0, 1, 3, 32'h33,   0, 0,  0,     7,  3,   1, 1, 7,  32'hAA,   0, 0, 0, 1, 0);
    tbl[7]  = row(0, 0, 0, 0,        0, 0,  0,     7,  3,   1, 1, 3,  32'h33,   0, 0, 0, 0, 1);
    tbl[8]  = row(0, 0, 0, 0,        0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 0, 0, 0);
    tbl[9]  = row(1, 1, 4, 32'h44,   1, 10, 32'hA1, 10, 0,  0, 0, 0,  0,        0, 0, 0, 1, 0);
    tbl[10] = row(1, 1, 4, 32'h44,   1, 11, 32'hB2, 10, 11, 0, 0, 0,  0,        1, 0, 0, 1, 1);
    tbl[11] = row(1, 1, 4, 32'h44,   1, 12, 32'hC3, 12, 11, 0, 0, 0,  0,        2, 1, 0, 0, 1);
    tbl[12] = row(0, 1, 4, 32'h44,   0, 0,  0,     10, 12,  0, 0, 0,  0,        2, 1, 1, 1, 0);
    tbl[13] = row(0, 1, 4, 32'h44,   0, 0,  0,     10, 11,  0, 1, 10, 32'hA1,   1, 0, 1, 1, 1);
    tbl[14] = row(0, 1, 4, 32'h44,   0, 0,  0,     10, 11,  1, 1, 11, 32'hB2,   0, 0, 1, 0, 1);
    tbl[15] = row(0, 0, 0, 0,        0, 0,  0,     12, 4,   1, 1, 4,  32'h44,   0, 0, 1, 0, 1);
    tbl[16] = row(0, 0, 0, 0,        0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 1, 0, 0);
    tbl[17] = row(0, 1, 0, 32'h55,   0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 1, 0, 0);
    tbl[18] = row(0, 0, 0, 0,        0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 1, 0, 0);
    tbl[19] = row(0, 0, 0, 0,        1, 0,  32'h66, 0, 0,   1, 0, 0,  0,        0, 0, 1, 0, 0);
    tbl[20] = row(0, 0, 0, 0,        0, 0,  0,     0,  0,   0, 0, 0,  0,        1, 0, 1, 0, 0);
    tbl[21] = row(0, 0, 0, 0,        0, 0,  0,     0,  0,   1, 0, 0,  0,        0, 0, 1, 0, 0);
    tbl[22] = row(1, 0, 0, 0,        1, 13, 32'hD1, 13, 0,  0, 0, 0,  0,        0, 0, 1, 1, 0);
    tbl[23] = row(1, 0, 0, 0,        1, 14, 32'hE2, 13, 14, 0, 0, 0,  0,        1, 0, 1, 1, 1);
    tbl[24] = row(0, 0, 0, 0,        1, 15, 32'hF3, 15, 13, 0, 0, 0,  0,        2, 1, 1, 1, 1);
    tbl[25] = row(0, 0, 0, 0,        0, 0,  0,     15, 14,  0, 1, 13, 32'hD1,   2, 1, 1, 1, 1);
    tbl[26] = row(0, 0, 0, 0,        0, 0,  0,     15, 13,  0, 1, 14, 32'hE2,   1, 0, 1, 1, 0);
    tbl[27] = row(0, 0, 0, 0,        0, 0,  0,     15, 0,   1, 1, 15, 32'hF3,   0, 0, 1, 1, 0);
    tbl[28] = row(0, 0, 0, 0,        0, 0,  0,     15, 0,   1, 0, 0,  0,        0, 0, 1, 0, 0);

    // Power-on reset, then the reset state itself
    repeat (2) begin
      drive(idle, 1'b1);
      model_step(idle, 1'b1);
    end
    drive(idle, 1'b0);
    chk("rst.regwrite", 32'(bus.regwrite), 0);
    chk("rst.wa",       32'(bus.wa),       0);
    chk("rst.wd",       bus.wd,            0);
    chk("rst.lq_count", 32'(bus.lq_count), 0);
    chk("rst.overflow", 32'(bus.overflow), 0);
    chk("rst.ld_full",  32'(bus.ld_full),  0);
    model_step(idle, 1'b0);

    for (int k = 0; k < NVEC; k++) begin
      drive(tbl[k].i, 1'b0);
      check_out(tbl[k].o, $sformatf("vec%0d", k));
      model_step(tbl[k].i, 1'b0);
    end

    for (int n = 0; n < 600; n++) begin
      in_t  v;
      out_t e;
      logic r;
      v.hold = ($urandom_range(0, 2) == 0);
      v.av   = $urandom_range(0, 1) == 1;
      v.awa  = ra_t'($urandom_range(0, 15));
      v.awd  = d_t'($urandom);
      v.lv   = $urandom_range(0, 1) == 1;
      v.lwa  = ra_t'($urandom_range(0, 15));
      v.lwd  = d_t'($urandom);
      v.ra1  = ra_t'($urandom_range(0, 15));
      v.ra2  = ra_t'($urandom_range(0, 15));
      r      = ($urandom_range(0, 99) == 0);
      drive(v, r);
      e = model_expect(v);
      check_out(e, $sformatf("rnd%0d", n));
      model_step(v, r);
    end

    // Reset with two queued loads and a dropped one pending
    drive(idle, 1'b1);
    model_step(idle, 1'b1);
    for (int k = 0; k < 3; k++) begin
      in_t v;
      v = idle;
      v.hold = 1; v.lv = 1; v.lwa = ra_t'(20 + k); v.lwd = d_t'(32'h100 + k);
      drive(v, 1'b0);
      model_step(v, 1'b0);
    end
    drive(idle, 1'b1);
    chk("mrst.pre_count",    32'(bus.lq_count), 2);
    chk("mrst.pre_overflow", 32'(bus.overflow), 1);
    model_step(idle, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(idle, 1'b0);
      chk($sformatf("mrst%0d.regwrite", k), 32'(bus.regwrite), 0);
      chk($sformatf("mrst%0d.lq_count", k), 32'(bus.lq_count), 0);
      chk($sformatf("mrst%0d.overflow", k), 32'(bus.overflow), 0);
      if (k == 0) begin
        chk("mrst.wa", 32'(bus.wa), 0);
        chk("mrst.wd", bus.wd, 0);
      end
      model_step(idle, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
